// File: rtl/sincronizador_pcs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sincronizador_pcs                                              |
// | Brief   : 1000BASE-X receive code-group synchronization state machine.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sincronizador_pcs #(
  parameter int GOOD_CGS_MAX = 3,
  parameter int GOOD_CGS_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_detect,
  input  logic       pudi_valid,
  input  logic [9:0] PUDI,
  input  logic       PUDI_COMMA,
  input  logic       PUDI_D,
  input  logic       PUDI_INVALID,
  output logic       code_sync_status,
  output logic       rx_even,
  output logic [9:0] pudi_out,
  output logic       pudi_out_valid
);

  typedef enum logic [3:0] {
    ST_LOSS = 4'd0,
    ST_CD1  = 4'd1,
    ST_AS1  = 4'd2,
    ST_CD2  = 4'd3,
    ST_AS2  = 4'd4,
    ST_CD3  = 4'd5,
    ST_SA1  = 4'd6,
    ST_SA2  = 4'd7,
    ST_SA2A = 4'd8,
    ST_SA3  = 4'd9,
    ST_SA3A = 4'd10,
    ST_SA4  = 4'd11,
    ST_SA4A = 4'd12
  } state_t;

  localparam logic [GOOD_CGS_W-1:0] c_good_max = GOOD_CGS_W'(GOOD_CGS_MAX);

  state_t                  r_state;
  logic [GOOD_CGS_W-1:0]   r_good_cgs;
  logic                    r_rx_even;
  logic                    r_status;
  logic [9:0]              r_pudi;
  logic                    r_pudi_valid;

  state_t                  w_state_next;
  logic [GOOD_CGS_W-1:0]   w_good_next;
  logic [GOOD_CGS_W-1:0]   w_good_inc;
  logic                    w_good_done;
  logic                    w_cgbad;
  logic                    w_even_next;
  logic                    w_sync_next;

  // A comma landing in the even slot is misaligned and counts as a bad code-group.
  assign w_cgbad     = PUDI_INVALID | (PUDI_COMMA & r_rx_even);
  assign w_good_inc  = (r_good_cgs == c_good_max) ? c_good_max : r_good_cgs + 1'b1;
  assign w_good_done = (w_good_inc == c_good_max);

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cgs;
    if (!signal_detect) begin
      w_state_next = ST_LOSS;
      w_good_next  = '0;
    end else if (pudi_valid) begin
      w_good_next = '0;
      case (r_state)
        ST_LOSS: if (PUDI_COMMA) w_state_next = ST_CD1;
        ST_CD1:  w_state_next = PUDI_D ? ST_AS1 : ST_LOSS;
        ST_CD2:  w_state_next = PUDI_D ? ST_AS2 : ST_LOSS;
        ST_CD3:  w_state_next = PUDI_D ? ST_SA1 : ST_LOSS;
        ST_AS1: begin
          if (!r_rx_even && PUDI_COMMA) w_state_next = ST_CD2;
          else if (w_cgbad)             w_state_next = ST_LOSS;
        end
        ST_AS2: begin
          if (!r_rx_even && PUDI_COMMA) w_state_next = ST_CD3;
          else if (w_cgbad)             w_state_next = ST_LOSS;
        end
        ST_SA1: if (w_cgbad) w_state_next = ST_SA2;
        // good_cgs is zero in the plain level state, so it shares the A-state logic.
        ST_SA2, ST_SA2A: begin
          if (w_cgbad)          w_state_next = ST_SA3;
          else if (w_good_done) w_state_next = ST_SA1;
          else begin
            w_state_next = ST_SA2A;
            w_good_next  = w_good_inc;
          end
        end
        ST_SA3, ST_SA3A: begin
          if (w_cgbad)          w_state_next = ST_SA4;
          else if (w_good_done) w_state_next = ST_SA2;
          else begin
            w_state_next = ST_SA3A;
            w_good_next  = w_good_inc;
          end
        end
        ST_SA4, ST_SA4A: begin
          if (w_cgbad)          w_state_next = ST_LOSS;
          else if (w_good_done) w_state_next = ST_SA3;
          else begin
            w_state_next = ST_SA4A;
            w_good_next  = w_good_inc;
          end
        end
        default: w_state_next = ST_LOSS;
      endcase
    end
  end

  assign w_even_next = (w_state_next inside {ST_CD1, ST_CD2, ST_CD3}) ? 1'b1 : ~r_rx_even;
  assign w_sync_next = w_state_next inside {ST_SA1, ST_SA2, ST_SA2A, ST_SA3, ST_SA3A,
                                            ST_SA4, ST_SA4A};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LOSS;
      r_good_cgs   <= '0;
      r_rx_even    <= 1'b0;
      r_status     <= 1'b0;
      r_pudi       <= '0;
      r_pudi_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_good_cgs   <= w_good_next;
      r_status     <= w_sync_next;
      r_pudi_valid <= pudi_valid;
      if (pudi_valid) begin
        r_rx_even <= w_even_next;
        r_pudi    <= PUDI;
      end
    end
  end

  assign code_sync_status = r_status;
  assign rx_even          = r_rx_even;
  assign pudi_out         = r_pudi;
  assign pudi_out_valid   = r_pudi_valid;

endmodule
`default_nettype wire

// File: tb/tb_sincronizador_pcs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sincronizador_pcs                                           |
// | Brief   : Directed self-checking bench for sincronizador_pcs.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sincronizador_pcs;

  localparam int GOOD_MAX = 3;
  localparam int K = 0;
  localparam int D = 1;
  localparam int I = 2;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sd = 1'b0;
  logic       pv = 1'b0;
  logic [9:0] pudi = '0;
  logic       comma = 1'b0;
  logic       dflag = 1'b0;
  logic       inv = 1'b0;
  logic       status;
  logic       even;
  logic [9:0] pudi_o;
  logic       pudi_ov;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  logic [9:0] last_pudi = '0;

  // Model: acquisition progress counts matched groups (odd = comma just seen),
  // once synced the error depth counts net bad groups, the run counts goods.
  bit         m_sync = 1'b0;
  int         m_acq = 0;
  int         m_depth = 0;
  int         m_run = 0;
  bit         m_even = 1'b0;
  bit         m_bad = 1'b0;
  logic [9:0] m_po = '0;
  bit         m_pov = 1'b0;

  sincronizador_pcs #(.GOOD_CGS_MAX(GOOD_MAX), .GOOD_CGS_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .signal_detect    (sd),
    .pudi_valid       (pv),
    .PUDI             (pudi),
    .PUDI_COMMA       (comma),
    .PUDI_D           (dflag),
    .PUDI_INVALID     (inv),
    .code_sync_status (status),
    .rx_even          (even),
    .pudi_out         (pudi_o),
    .pudi_out_valid   (pudi_ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = 1'b0; m_acq = 0; m_depth = 0; m_run = 0; m_even = 1'b0;
      m_po = '0; m_pov = 1'b0;
    end else begin
      m_bad = inv || (comma && m_even);
      if (!sd) begin
        m_sync = 1'b0; m_acq = 0; m_depth = 0; m_run = 0;
      end else if (pv) begin
        if (!m_sync) begin
          if (m_acq == 0) begin
            if (comma) m_acq = 1;
          end else if (m_acq % 2 == 1) begin
            if (!dflag) m_acq = 0;
            else if (m_acq == 5) begin
              m_sync = 1'b1; m_acq = 0; m_depth = 0; m_run = 0;
            end else m_acq++;
          end else begin
            if (!m_even && comma) m_acq++;
            else if (m_bad) m_acq = 0;
          end
        end else if (m_bad) begin
          m_depth++; m_run = 0;
          if (m_depth == 4) begin
            m_sync = 1'b0; m_acq = 0; m_depth = 0;
          end
        end else if (m_depth > 0) begin
          m_run++;
          if (m_run == GOOD_MAX) begin
            m_depth--; m_run = 0;
          end
        end
      end
      if (pv) begin
        m_even = (!m_sync && (m_acq % 2 == 1)) ? 1'b1 : !m_even;
        m_po   = pudi;
      end
      m_pov = pv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_status", status, m_sync);
      chk("model_rx_even", even, m_even);
      chk("model_pudi_out", pudi_o, m_po);
      chk("model_pudi_out_valid", pudi_ov, m_pov);
    end
  end

  task automatic grp(input int kind, input logic sdv = 1'b1);
    @(negedge clk); #1;
    sd    = sdv;
    pv    = (kind != N);
    comma = (kind == K);
    dflag = (kind == D);
    inv   = (kind == I);
    pudi  = (kind == K) ? 10'h0FA : 10'($urandom);
    if (kind != N) last_pudi = pudi;
    @(posedge clk); #1;
  endtask

  task automatic acquire();
    for (int n = 0; n < 3; n++) begin
      grp(K);
      grp(D);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", status, 1'b0);
    chk("reset_rx_even", even, 1'b0);
    chk("reset_pudi_out", pudi_o, 10'h000);
    chk("reset_pudi_out_valid", pudi_ov, 1'b0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Acquisition
    grp(K);
    chk("acq_first_comma_even", even, 1'b1);
    chk("acq_first_comma_status", status, 1'b0);
    grp(D); grp(K); grp(D); grp(K);
    chk("acq_before_last_d", status, 1'b0);
    grp(D);
    chk("acq_status_up", status, 1'b1);
    chk("acq_even_after_d", even, 1'b0);
    chk("acq_pudi_out", pudi_o, last_pudi);

    // Recovery to level 1 after a single error, then four errors lose sync
    grp(I); grp(D); grp(D); grp(D);
    chk("recover_status", status, 1'b1);
    grp(I); grp(I); grp(I);
    chk("three_bad_still_ok", status, 1'b1);
    grp(I);
    chk("fourth_bad_loss", status, 1'b0);

    // Loss with errors spaced by fewer than three goods
    acquire();
    grp(I); grp(D); grp(D); grp(I); grp(D); grp(I); grp(D); grp(D);
    chk("spaced_bad_third", status, 1'b1);
    grp(I);
    chk("spaced_bad_fourth", status, 1'b0);

    // Misaligned comma in ACQUIRE_SYNC_1
    grp(K); grp(D); grp(D); grp(K);
    chk("misaligned_status", status, 1'b0);
    grp(D); grp(K); grp(D); grp(K); grp(D);
    chk("misaligned_restart", status, 1'b0);
    grp(K); grp(D);
    chk("misaligned_reacquire", status, 1'b1);

    // signal_detect drop
    grp(D, 1'b0);
    chk("sd_drop_status", status, 1'b0);
    grp(K, 1'b0);
    grp(D);
    chk("sd_comma_ignored", status, 1'b0);
    acquire();
    chk("sd_reacquire", status, 1'b1);

    // Acquisition with pudi_valid gaps
    grp(I); grp(I); grp(I); grp(I);
    for (int n = 0; n < 3; n++) begin
      grp(K); grp(D); grp(N);
      chk("gap_valid_low", pudi_ov, 1'b0);
      chk("gap_pudi_hold", pudi_o, last_pudi);
      if (n < 2) chk("gap_status_low", status, 1'b0);
    end
    chk("gap_status_up", status, 1'b1);

    // Asynchronous reset mid-stream
    grp(D);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_status", status, 1'b0);
    chk("async_rst_rx_even", even, 1'b0);
    chk("async_rst_pudi_out", pudi_o, 10'h000);
    chk("async_rst_pudi_valid", pudi_ov, 1'b0);
    pv = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    acquire();
    chk("post_reset_acquire", status, 1'b1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
